// File: rtl/mmio_input_conditioner_pkg.sv
// Shared constants for the board input conditioner: default widths, debounce timing
// and the MMIO register map that the memory block decodes.
package mmio_input_conditioner_pkg;

    localparam int KEY_WIDTH_DEF       = 4;
    localparam int SW_WIDTH_DEF        = 10;
    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 50000;
    localparam int CNT_WIDTH_DEF       = 16;

    // Word addresses seen by software; the key_event register sits next to the level registers.
    typedef enum logic [31:0] {
        ADDR_KEY     = 32'h0000_FF00,
        ADDR_SW      = 32'h0000_FF04,
        ADDR_KEY_EVT = 32'h0000_FF08
    } mmio_addr_e;

    // Sticky flag update: a new press always wins over a simultaneous clear.
    function automatic logic [KEY_WIDTH_DEF-1:0] sticky_next(
        input logic [KEY_WIDTH_DEF-1:0] flags,
        input logic [KEY_WIDTH_DEF-1:0] press,
        input logic [KEY_WIDTH_DEF-1:0] clr
    );
        return press | (flags & ~clr);
    endfunction

endpackage

// File: rtl/mmio_input_conditioner_if.sv
// Pin/MMIO-side bundle of the input conditioner. master = board pins plus MMIO write
// decode, slave = the conditioner itself.
interface mmio_input_conditioner_if #(
    parameter int KEY_WIDTH = 4,
    parameter int SW_WIDTH  = 10
);
    logic [KEY_WIDTH-1:0] key_n_raw;
    logic [SW_WIDTH-1:0]  sw_raw;
    logic [KEY_WIDTH-1:0] key_event_clr;
    logic [KEY_WIDTH-1:0] key_out;
    logic [SW_WIDTH-1:0]  sw_out;
    logic [KEY_WIDTH-1:0] key_press;
    logic [KEY_WIDTH-1:0] key_event;

    modport master (
        output key_n_raw, sw_raw, key_event_clr,
        input  key_out, sw_out, key_press, key_event
    );

    modport slave (
        input  key_n_raw, sw_raw, key_event_clr,
        output key_out, sw_out, key_press, key_event
    );
endinterface

// File: rtl/mmio_input_conditioner_debounce_bit.sv
// One conditioned input bit: synchroniser chain, optional inversion, and a counter that
// only lets the stable level follow after DEBOUNCE_CYCLES consecutive disagreeing samples.
module mmio_input_conditioner_debounce_bit #(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter int   CNT_WIDTH       = 16,
    parameter logic RESET_VAL       = 1'b0,
    parameter logic INVERT          = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic level_o
);

    localparam logic [CNT_WIDTH-1:0] TERM_CNT = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [CNT_WIDTH-1:0]   cnt_d;
    logic                   level_q;
    logic                   level_d;
    logic                   sample;

    assign sync_d  = {sync_q[SYNC_STAGES-2:0], raw_i};
    assign sample  = sync_q[SYNC_STAGES-1] ^ INVERT;
    assign level_o = level_q;

    // Any match with the held level, or an accept, restarts the count from zero.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sample != level_q) begin
            if (cnt_q == TERM_CNT) begin
                level_d = sample;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= {SYNC_STAGES{RESET_VAL}};
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/mmio_input_conditioner.sv
// Conditions raw board keys/switches into clean MMIO levels, plus per-key press pulses
// and software-clearable sticky press flags. 2**CNT_WIDTH must exceed DEBOUNCE_CYCLES.
module mmio_input_conditioner
    import mmio_input_conditioner_pkg::*;
#(
    parameter int KEY_WIDTH       = KEY_WIDTH_DEF,
    parameter int SW_WIDTH        = SW_WIDTH_DEF,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_WIDTH       = CNT_WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    mmio_input_conditioner_if.slave  bus
);

    logic [KEY_WIDTH-1:0] q_key;
    logic [SW_WIDTH-1:0]  q_sw;
    logic [KEY_WIDTH-1:0] q_key_d_q;
    logic [KEY_WIDTH-1:0] key_press_q;
    logic [KEY_WIDTH-1:0] key_press_d;
    logic [KEY_WIDTH-1:0] key_event_q;
    logic [KEY_WIDTH-1:0] key_event_d;

    // Keys are active-low at the pin; the chain idles at 1 so reset reads as "not pressed".
    for (genvar i = 0; i < KEY_WIDTH; i++) begin : g_key
        mmio_input_conditioner_debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_WIDTH       (CNT_WIDTH),
            .RESET_VAL       (1'b1),
            .INVERT          (1'b1)
        ) u_key (
            .clk     (clk),
            .reset   (reset),
            .raw_i   (bus.key_n_raw[i]),
            .level_o (q_key[i])
        );
    end

    for (genvar i = 0; i < SW_WIDTH; i++) begin : g_sw
        mmio_input_conditioner_debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_WIDTH       (CNT_WIDTH),
            .RESET_VAL       (1'b0),
            .INVERT          (1'b0)
        ) u_sw (
            .clk     (clk),
            .reset   (reset),
            .raw_i   (bus.sw_raw[i]),
            .level_o (q_sw[i])
        );
    end

    always_comb begin
        key_press_d = q_key & ~q_key_d_q;
        key_event_d = key_press_q | (key_event_q & ~bus.key_event_clr);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_key_d_q   <= '0;
            key_press_q <= '0;
            key_event_q <= '0;
        end else begin
            q_key_d_q   <= q_key;
            key_press_q <= key_press_d;
            key_event_q <= key_event_d;
        end
    end

    assign bus.key_out   = q_key;
    assign bus.sw_out    = q_sw;
    assign bus.key_press = key_press_q;
    assign bus.key_event = key_event_q;

endmodule

// File: tb/tb_mmio_input_conditioner.sv
// Bench for the input conditioner: window-based reference model checked every cycle,
// plus directed scenarios with hand-computed timing.
module tb_mmio_input_conditioner;

    localparam int KW  = 4;
    localparam int SWW = 10;
    localparam int NB  = KW + SWW;
    localparam int DEB = 4;

    logic clk;
    logic reset;

    int vectors;
    int miscompares;
    int press_cnt [KW];

    mmio_input_conditioner_if #(.KEY_WIDTH(KW), .SW_WIDTH(SWW)) ifc ();

    mmio_input_conditioner #(
        .KEY_WIDTH       (KW),
        .SW_WIDTH        (SWW),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (DEB),
        .CNT_WIDTH       (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: s is the raw level two samples late (keys inverted). A bit's level
    // flips once the last DEB samples of s all disagree with it.
    logic [NB-1:0] m_d1, m_d2, m_q, m_newq;
    logic [NB-1:0] m_hist [DEB-1];
    logic [KW-1:0] m_rose, m_press, m_event;
    logic          m_all;

    always_comb begin
        m_newq = m_q;
        m_all  = 1'b1;
        for (int b = 0; b < NB; b++) begin
            m_all = (m_d2[b] != m_q[b]);
            for (int j = 0; j < DEB - 1; j++)
                if (m_hist[j][b] == m_q[b]) m_all = 1'b0;
            if (m_all) m_newq[b] = ~m_q[b];
        end
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_d1    <= '0;
            m_d2    <= '0;
            m_q     <= '0;
            m_rose  <= '0;
            m_press <= '0;
            m_event <= '0;
            for (int j = 0; j < DEB - 1; j++) m_hist[j] <= '0;
        end else begin
            for (int j = DEB - 2; j > 0; j--) m_hist[j] <= m_hist[j-1];
            m_hist[0] <= m_d2;
            m_q       <= m_newq;
            m_rose    <= m_newq[KW-1:0] & ~m_q[KW-1:0];
            m_press   <= m_rose;
            m_event   <= (m_event & ~ifc.key_event_clr) | m_press;
            m_d2      <= m_d1;
            m_d1      <= {ifc.sw_raw, ~ifc.key_n_raw};
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        check("model key_out",   32'(ifc.key_out),   32'(m_q[KW-1:0]));
        check("model sw_out",    32'(ifc.sw_out),    32'(m_q[NB-1:KW]));
        check("model key_press", 32'(ifc.key_press), 32'(m_press));
        check("model key_event", 32'(ifc.key_event), 32'(m_event));
        for (int i = 0; i < KW; i++)
            if (ifc.key_press[i] === 1'b1) press_cnt[i] <= press_cnt[i] + 1;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    int p0;

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < KW; i++) press_cnt[i] = 0;
        reset             = 1'b0;
        ifc.key_n_raw     = 4'hF;
        ifc.sw_raw        = 10'h3FF;
        ifc.key_event_clr = '0;

        // 1: reset, then switches qualify 6 edges after release
        step(3);
        check("t1 rst key_out",   32'(ifc.key_out),   32'h0);
        check("t1 rst sw_out",    32'(ifc.sw_out),    32'h0);
        check("t1 rst key_press", 32'(ifc.key_press), 32'h0);
        check("t1 rst key_event", 32'(ifc.key_event), 32'h0);
        reset = 1'b1;
        step(5);
        check("t1 sw_out edge5", 32'(ifc.sw_out), 32'h0);
        step(1);
        check("t1 sw_out edge6",  32'(ifc.sw_out),  32'h3FF);
        check("t1 key_out edge6", 32'(ifc.key_out), 32'h0);

        // 2: key 0 press
        ifc.key_n_raw = 4'hE;
        step(5);
        check("t2 key_out edge5", 32'(ifc.key_out), 32'h0);
        step(1);
        check("t2 key_out edge6",   32'(ifc.key_out),   32'h1);
        check("t2 key_press edge6", 32'(ifc.key_press), 32'h0);
        step(1);
        check("t2 key_press edge7", 32'(ifc.key_press), 32'h1);
        check("t2 key_event edge7", 32'(ifc.key_event), 32'h0);
        step(1);
        check("t2 key_press edge8", 32'(ifc.key_press), 32'h0);
        check("t2 key_event edge8", 32'(ifc.key_event), 32'h1);

        // 3: key 1 bounces, never qualifies
        ifc.key_n_raw = 4'hC; step(3);
        ifc.key_n_raw = 4'hE; step(1);
        ifc.key_n_raw = 4'hC; step(3);
        ifc.key_n_raw = 4'hE; step(10);
        check("t3 key_out",     32'(ifc.key_out),   32'h1);
        check("t3 key_event",   32'(ifc.key_event), 32'h1);
        check("t3 press count", 32'(press_cnt[1]),  32'h0);

        // 4: set-wins on simultaneous press and clear, then plain clear
        ifc.key_n_raw = 4'hA; step(8);
        check("t4 key_event set", 32'(ifc.key_event), 32'h5);
        ifc.key_n_raw = 4'hE; step(8);
        check("t4 key_out released", 32'(ifc.key_out), 32'h1);
        ifc.key_n_raw = 4'hA; step(7);
        check("t4 key_press again", 32'(ifc.key_press), 32'h4);
        ifc.key_event_clr = 4'h4; step(1);
        ifc.key_event_clr = 4'h0;
        check("t4 set wins", 32'(ifc.key_event), 32'h5);
        step(2);
        ifc.key_event_clr = 4'h4; step(1);
        ifc.key_event_clr = 4'h0;
        check("t4 clear", 32'(ifc.key_event), 32'h1);
        step(1);
        ifc.key_event_clr = 4'h4; step(1);
        ifc.key_event_clr = 4'h0;
        check("t4 clear idle", 32'(ifc.key_event), 32'h1);

        // 5: reset two cycles before switch 9 would qualify
        ifc.sw_raw = 10'h000; step(8);
        check("t5 sw_out low", 32'(ifc.sw_out), 32'h0);
        ifc.sw_raw = 10'h200; step(4);
        reset = 1'b0; step(2);
        check("t5 sw_out in reset", 32'(ifc.sw_out), 32'h0);
        reset = 1'b1;
        step(5);
        check("t5 sw_out edge5", 32'(ifc.sw_out), 32'h0);
        step(1);
        check("t5 sw_out edge6",  32'(ifc.sw_out),  32'h200);
        check("t5 key_out edge6", 32'(ifc.key_out), 32'h5);

        // 6: key 3 held 20 cycles, one pulse, release after 6 edges without a pulse
        p0 = press_cnt[3];
        ifc.key_n_raw = 4'h2; step(20);
        check("t6 key_out held", 32'(ifc.key_out), 32'hD);
        ifc.key_n_raw = 4'hA;
        step(5);
        check("t6 key_out edge5", 32'(ifc.key_out[3]), 32'h1);
        step(1);
        check("t6 key_out edge6", 32'(ifc.key_out[3]), 32'h0);
        step(4);
        check("t6 press count", 32'(press_cnt[3] - p0), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
